// File: rtl/nim_turn_controller_if.sv
// Bundles the front-end controls and the controller's game/score outputs.
// No latency of its own; purely a wiring bundle.
// No backpressure: the buttons are levels and the outputs are registered pulses or levels.
interface nim_turn_controller_if;
    logic       confirm;
    logic [1:0] heap_sel;
    logic [2:0] take_cnt;
    logic       new_game;
    logic       clear_scores;
    logic [3:0] heap0;
    logic [3:0] heap1;
    logic [3:0] heap2;
    logic       turn;
    logic       il;
    logic       dl;
    logic       ir;
    logic       dr;
    logic       resetScore;
    logic       game_over;
    logic       winner;

    // Front end (buttons/switches) side
    modport master (
        output confirm, heap_sel, take_cnt, new_game, clear_scores,
        input  heap0, heap1, heap2, turn, il, dl, ir, dr, resetScore, game_over, winner
    );

    // Controller side
    modport slave (
        input  confirm, heap_sel, take_cnt, new_game, clear_scores,
        output heap0, heap1, heap2, turn, il, dl, ir, dr, resetScore, game_over, winner
    );
endinterface

// File: rtl/nim_turn_controller.sv
// Sequences one three-heap Nim game and drives the two scoreboards' inc/dec/clear inputs.
// Moves land on the edge that sees the confirm rise; score pulses appear the cycle after their cause.
// No backpressure: rises arriving outside the state that honours them are discarded.
module nim_turn_controller #(
    parameter int HEAP0_INIT = 3,
    parameter int HEAP1_INIT = 5,
    parameter int HEAP2_INIT = 7,
    parameter int MAX_TAKE   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    nim_turn_controller_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_TURN  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam logic [3:0] H0_INIT  = 4'(HEAP0_INIT);
    localparam logic [3:0] H1_INIT  = 4'(HEAP1_INIT);
    localparam logic [3:0] H2_INIT  = 4'(HEAP2_INIT);
    localparam logic [3:0] MAX_TK   = 4'(MAX_TAKE);

    state_t     state_q, state_d;
    logic       confirm_prev_q, confirm_prev_d;
    logic       new_game_prev_q, new_game_prev_d;
    logic       clear_prev_q, clear_prev_d;
    logic [3:0] heap_q [3];
    logic [3:0] heap_d [3];
    logic       turn_q, turn_d;
    logic       winner_q, winner_d;
    logic       game_over_q, game_over_d;
    logic       il_q, il_d, dl_q, dl_d, ir_q, ir_d, dr_q, dr_d;
    logic       reset_score_q, reset_score_d;

    logic       confirm_rise, new_game_rise, clear_rise;
    logic [3:0] sel_cnt;
    logic [3:0] take_w;
    logic       move_legal;
    logic       all_zero;

    assign confirm_rise  = bus.confirm & ~confirm_prev_q;
    assign new_game_rise = bus.new_game & ~new_game_prev_q;
    assign clear_rise    = bus.clear_scores & ~clear_prev_q;
    assign take_w        = {1'b0, bus.take_cnt};
    assign all_zero      = (heap_q[0] == 4'd0) && (heap_q[1] == 4'd0) && (heap_q[2] == 4'd0);

    // Count in the targeted heap and the legality verdict for the presented move
    always_comb begin
        sel_cnt = 4'd0;
        for (int i = 0; i < 3; i++) begin
            if (bus.heap_sel == 2'(i)) sel_cnt = heap_q[i];
        end
        move_legal = (bus.heap_sel != 2'd3) && (take_w != 4'd0) &&
                     (take_w <= MAX_TK) && (take_w <= sel_cnt);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_TURN;
        else       state_q <= state_d;
    end

    // Next-state: a legal move always passes through one CHECK cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TURN:  if (confirm_rise && move_legal) state_d = ST_CHECK;
            ST_CHECK: state_d = all_zero ? ST_OVER : ST_TURN;
            ST_OVER:  if (new_game_rise) state_d = ST_TURN;
            default:  state_d = ST_TURN;
        endcase
    end

    // Game datapath and score pulses for the state being left
    always_comb begin
        confirm_prev_d  = bus.confirm;
        new_game_prev_d = bus.new_game;
        clear_prev_d    = bus.clear_scores;
        heap_d          = heap_q;
        turn_d          = turn_q;
        winner_d        = winner_q;
        game_over_d     = game_over_q;
        il_d            = 1'b0;
        dl_d            = 1'b0;
        ir_d            = 1'b0;
        dr_d            = 1'b0;
        reset_score_d   = clear_rise;
        case (state_q)
            ST_TURN: begin
                if (confirm_rise) begin
                    if (move_legal) begin
                        for (int i = 0; i < 3; i++) begin
                            if (bus.heap_sel == 2'(i)) heap_d[i] = heap_q[i] - take_w;
                        end
                    end else begin
                        dl_d = ~turn_q;
                        dr_d = turn_q;
                    end
                end
            end
            ST_CHECK: begin
                if (all_zero) begin
                    // Normal play: whoever took the last object wins
                    winner_d    = turn_q;
                    game_over_d = 1'b1;
                    il_d        = ~turn_q;
                    ir_d        = turn_q;
                end else begin
                    turn_d = ~turn_q;
                end
            end
            ST_OVER: begin
                if (new_game_rise) begin
                    heap_d[0]   = H0_INIT;
                    heap_d[1]   = H1_INIT;
                    heap_d[2]   = H2_INIT;
                    turn_d      = ~winner_q;
                    game_over_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any pulse in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            confirm_prev_q  <= 1'b0;
            new_game_prev_q <= 1'b0;
            clear_prev_q    <= 1'b0;
            heap_q[0]       <= H0_INIT;
            heap_q[1]       <= H1_INIT;
            heap_q[2]       <= H2_INIT;
            turn_q          <= 1'b0;
            winner_q        <= 1'b0;
            game_over_q     <= 1'b0;
            il_q            <= 1'b0;
            dl_q            <= 1'b0;
            ir_q            <= 1'b0;
            dr_q            <= 1'b0;
            reset_score_q   <= 1'b0;
        end else begin
            confirm_prev_q  <= confirm_prev_d;
            new_game_prev_q <= new_game_prev_d;
            clear_prev_q    <= clear_prev_d;
            heap_q          <= heap_d;
            turn_q          <= turn_d;
            winner_q        <= winner_d;
            game_over_q     <= game_over_d;
            il_q            <= il_d;
            dl_q            <= dl_d;
            ir_q            <= ir_d;
            dr_q            <= dr_d;
            reset_score_q   <= reset_score_d;
        end
    end

    assign bus.heap0      = heap_q[0];
    assign bus.heap1      = heap_q[1];
    assign bus.heap2      = heap_q[2];
    assign bus.turn       = turn_q;
    assign bus.il         = il_q;
    assign bus.dl         = dl_q;
    assign bus.ir         = ir_q;
    assign bus.dr         = dr_q;
    assign bus.resetScore = reset_score_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
endmodule

// File: tb/tb_nim_turn_controller.sv
// Directed bench for the Nim turn controller with a game-level reference model.
// Inputs change 2 time units after a rising edge; outputs are compared on every falling edge.
// No backpressure on either side; every wait is a fixed number of cycles.
module tb_nim_turn_controller;
    localparam int H0 = 3;
    localparam int H1 = 5;
    localparam int H2 = 7;
    localparam int MT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nim_turn_controller_if bus();

    nim_turn_controller #(
        .HEAP0_INIT(H0), .HEAP1_INIT(H1), .HEAP2_INIT(H2), .MAX_TAKE(MT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(string name, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference model: heaps as integers, whose move it is, and game phase
    // (0 = waiting for a move, 1 = move just made, 2 = game finished).
    int  m_heap [3];
    int  m_mover, m_win, m_phase;
    bit  m_over;
    bit  e_il, e_dl, e_ir, e_dr, e_rs;
    bit  p_c, p_n, p_s;

    // Model advance on each clock; reset is honoured immediately
    always @(posedge clk or posedge reset) begin
        bit cr, nr, sr, legal;
        int sel, tk;
        if (reset) begin
            m_heap[0] = H0; m_heap[1] = H1; m_heap[2] = H2;
            m_mover = 0; m_win = 0; m_phase = 0; m_over = 0;
            e_il = 0; e_dl = 0; e_ir = 0; e_dr = 0; e_rs = 0;
            p_c = 0; p_n = 0; p_s = 0;
        end else begin
            cr = bus.confirm && !p_c;
            nr = bus.new_game && !p_n;
            sr = bus.clear_scores && !p_s;
            e_il = 0; e_dl = 0; e_ir = 0; e_dr = 0;
            e_rs = sr;
            sel = int'(bus.heap_sel);
            tk  = int'(bus.take_cnt);
            legal = 0;
            if (sel < 3) legal = (tk >= 1) && (tk <= MT) && (tk <= m_heap[sel]);
            if (m_phase == 0) begin
                if (cr) begin
                    if (legal) begin
                        m_heap[sel] = m_heap[sel] - tk;
                        m_phase = 1;
                    end else begin
                        e_dl = (m_mover == 0);
                        e_dr = (m_mover == 1);
                    end
                end
            end else if (m_phase == 1) begin
                if (m_heap[0] + m_heap[1] + m_heap[2] == 0) begin
                    m_win = m_mover; m_over = 1; m_phase = 2;
                    e_il = (m_mover == 0);
                    e_ir = (m_mover == 1);
                end else begin
                    m_mover = 1 - m_mover;
                    m_phase = 0;
                end
            end else begin
                if (nr) begin
                    m_heap[0] = H0; m_heap[1] = H1; m_heap[2] = H2;
                    m_mover = 1 - m_win; m_over = 0; m_phase = 0;
                end
            end
            p_c = bus.confirm; p_n = bus.new_game; p_s = bus.clear_scores;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [18:0] got, exp;
        got = {bus.heap0, bus.heap1, bus.heap2, bus.turn, bus.il, bus.dl, bus.ir, bus.dr,
               bus.resetScore, bus.game_over, bus.game_over & bus.winner};
        exp = {4'(m_heap[0]), 4'(m_heap[1]), 4'(m_heap[2]), m_mover[0], e_il, e_dl, e_ir, e_dr,
               e_rs, m_over, m_over & m_win[0]};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL cycle_compare at %0t: got %h, want %h", $time, got, exp);
        end
    end

    // Pulse tallies for the hand-computed expectations
    int n_il = 0, n_dl = 0, n_ir = 0, n_dr = 0, n_rs = 0;
    always @(negedge clk) begin
        if (bus.il === 1'b1) n_il++;
        if (bus.dl === 1'b1) n_dl++;
        if (bus.ir === 1'b1) n_ir++;
        if (bus.dr === 1'b1) n_dr++;
        if (bus.resetScore === 1'b1) n_rs++;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic move(int sel, int tk, int hold);
        bus.heap_sel = 2'(sel);
        bus.take_cnt = 3'(tk);
        bus.confirm  = 1'b1;
        tick(hold);
        bus.confirm  = 1'b0;
        tick(3);
    endtask

    initial begin
        int saved;
        bus.confirm = 0; bus.heap_sel = 0; bus.take_cnt = 0;
        bus.new_game = 0; bus.clear_scores = 0;
        reset = 0;
        #1 reset = 1;
        tick(2);
        reset = 0;
        tick(1);

        // Reset state
        check("reset_heap0", int'(bus.heap0), 3);
        check("reset_heap1", int'(bus.heap1), 5);
        check("reset_heap2", int'(bus.heap2), 7);
        check("reset_turn", int'(bus.turn), 0);
        check("reset_game_over", int'(bus.game_over), 0);

        // Left takes 2 from heap 1, confirm held for 20 cycles: one move only
        move(1, 2, 20);
        check("first_move_heap1", int'(bus.heap1), 3);
        check("first_move_total", int'(bus.heap0) + int'(bus.heap1) + int'(bus.heap2), 13);
        check("first_move_turn", int'(bus.turn), 1);
        check("first_move_no_pulses", n_il + n_dl + n_ir + n_dr, 0);

        // Right: take too many, take zero, invalid heap
        move(0, 4, 1);
        move(0, 0, 1);
        move(3, 1, 1);
        check("illegal_dr_count", n_dr, 3);
        check("illegal_heap0", int'(bus.heap0), 3);
        check("illegal_heap2", int'(bus.heap2), 7);
        check("illegal_turn", int'(bus.turn), 1);

        // Clear together with an illegal move: both pulses in the same cycle
        bus.clear_scores = 1;
        move(2, 0, 1);
        bus.clear_scores = 0;
        check("clear_with_illegal_dr", n_dr, 4);
        check("clear_with_illegal_rs", n_rs, 1);

        // new_game rise during TURN is ignored
        bus.new_game = 1; tick(2); bus.new_game = 0; tick(1);

        // Play out: left removes the last object
        move(2, 3, 1);
        move(2, 3, 1);
        move(2, 1, 1);
        move(0, 3, 1);
        move(1, 2, 1);
        check("endgame_heap1", int'(bus.heap1), 1);
        check("endgame_turn", int'(bus.turn), 0);
        move(1, 1, 1);
        check("win_game_over", int'(bus.game_over), 1);
        check("win_winner", int'(bus.winner), 0);
        check("win_il_count", n_il, 1);
        check("win_ir_count", n_ir, 0);

        // confirm in GAME_OVER is ignored
        move(0, 1, 1);
        check("over_dl_count", n_dl, 0);

        // New game: loser (right) opens
        bus.new_game = 1; tick(1); bus.new_game = 0; tick(2);
        check("new_game_heap0", int'(bus.heap0), 3);
        check("new_game_heap1", int'(bus.heap1), 5);
        check("new_game_heap2", int'(bus.heap2), 7);
        check("new_game_turn", int'(bus.turn), 1);
        check("new_game_over", int'(bus.game_over), 0);

        // clear_scores held several cycles: one pulse
        bus.clear_scores = 1; tick(3); bus.clear_scores = 0; tick(2);
        check("clear_rs_count", n_rs, 2);

        // Reset during CHECK: heaps reload, no score pulse follows
        saved = n_il + n_dl + n_ir + n_dr;
        bus.heap_sel = 0; bus.take_cnt = 1; bus.confirm = 1;
        tick(1);
        reset = 1; bus.confirm = 0;
        #1;
        check("reset_mid_check_heap0", int'(bus.heap0), 3);
        tick(1);
        reset = 0;
        tick(3);
        check("reset_mid_check_turn", int'(bus.turn), 0);
        check("reset_mid_check_pulses", n_il + n_dl + n_ir + n_dr, saved);

        // Reset while a dec pulse is high: it drops at once
        bus.heap_sel = 3; bus.take_cnt = 1; bus.confirm = 1;
        tick(1);
        reset = 1; bus.confirm = 0;
        #1;
        check("reset_mid_pulse_dl", int'(bus.dl), 0);
        tick(1);
        reset = 0;
        tick(3);
        check("reset_mid_pulse_count", n_il + n_dl + n_ir + n_dr, saved);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
